// File: rtl/alu_op_sequencer.sv
// Steps a small {opcode, operand} program into the ALU, one entry at a time,
// and reports the ALU result after a fixed settle time.
module alu_op_sequencer #(
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   prog_len_i,
    input  logic              prog_we_i,
    input  logic [ADDR_W-1:0] prog_addr_i,
    input  logic [11:0]       prog_wdata_i,
    input  logic [7:0]        alu_y_i,
    output logic [3:0]        alu_sel_o,
    output logic [7:0]        alu_data_o,
    output logic              alu_enable_o,
    output logic [7:0]        result_o,
    output logic              result_valid_o,
    output logic [ADDR_W-1:0] result_index_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned     Depth   = 2 ** ADDR_W;
    localparam int unsigned     CntW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [ADDR_W:0] MaxLen  = (ADDR_W + 1)'(Depth);
    localparam logic [CntW-1:0] CntInit = CntW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWait,
        StCapture,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [11:0]       entry_q, entry_d;
    logic [7:0]        result_q, result_d;
    logic [ADDR_W-1:0] result_index_q, result_index_d;
    logic              result_valid_q, result_valid_d;
    logic [ADDR_W:0]   pc_inc;

    logic [11:0] mem_q [Depth];

    // Program memory deliberately has no reset; contents survive a mid-run reset.
    always_ff @(posedge clock_i) begin
        if (!reset_i && prog_we_i && (state_q == StIdle)) begin
            mem_q[prog_addr_i] <= prog_wdata_i;
        end
    end

    assign pc_inc = {1'b0, pc_q} + 1'b1;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        entry_d        = entry_q;
        result_d       = result_q;
        result_index_d = result_index_q;
        result_valid_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    len_d   = (prog_len_i > MaxLen) ? MaxLen : prog_len_i;
                    pc_d    = '0;
                    state_d = (prog_len_i == '0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                entry_d = mem_q[pc_q];
                state_d = StIssue;
            end
            StIssue: begin
                cnt_d   = CntInit;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StCapture: begin
                // Opcodes 0xD..0xF (store/swap/load) produce no reportable Y.
                if (entry_q[11:8] <= 4'hC) begin
                    result_d       = alu_y_i;
                    result_index_d = pc_q;
                    result_valid_d = 1'b1;
                end
                if (pc_inc == len_q) begin
                    state_d = StDone;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = StFetch;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q        <= StIdle;
            pc_q           <= '0;
            len_q          <= '0;
            cnt_q          <= '0;
            entry_q        <= '0;
            result_q       <= '0;
            result_index_q <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            len_q          <= len_d;
            cnt_q          <= cnt_d;
            entry_q        <= entry_d;
            result_q       <= result_d;
            result_index_q <= result_index_d;
            result_valid_q <= result_valid_d;
        end
    end

    // The fetched entry drives the ALU bus and holds until the next fetch.
    assign alu_sel_o      = entry_q[11:8];
    assign alu_data_o     = entry_q[7:0];
    assign alu_enable_o   = (state_q == StIssue);
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign result_index_o = result_index_q;
    assign busy_o         = (state_q != StIdle);
    assign done_o         = (state_q == StDone);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; the ALU is modelled as Y = 0x30 + data + sel.
module tb_alu_op_sequencer;

    localparam int unsigned ADDR_W = 4;

    logic              clock;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   prog_len;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [11:0]       prog_wdata;
    logic [7:0]        alu_y;
    logic [3:0]        alu_sel;
    logic [7:0]        alu_data;
    logic              alu_enable;
    logic [7:0]        result;
    logic              result_valid;
    logic [ADDR_W-1:0] result_index;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;
    int en_cnt    = 0;
    int rv_cnt    = 0;
    int rv_double = 0;
    logic rv_prev = 1'b0;

    alu_op_sequencer #(
        .ADDR_W        (ADDR_W),
        .SETTLE_CYCLES (2)
    ) dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .start_i        (start),
        .prog_len_i     (prog_len),
        .prog_we_i      (prog_we),
        .prog_addr_i    (prog_addr),
        .prog_wdata_i   (prog_wdata),
        .alu_y_i        (alu_y),
        .alu_sel_o      (alu_sel),
        .alu_data_o     (alu_data),
        .alu_enable_o   (alu_enable),
        .result_o       (result),
        .result_valid_o (result_valid),
        .result_index_o (result_index),
        .busy_o         (busy),
        .done_o         (done)
    );

    assign alu_y = 8'h30 + alu_data + {4'h0, alu_sel};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        if (alu_enable) en_cnt <= en_cnt + 1;
        if (result_valid) begin
            rv_cnt <= rv_cnt + 1;
            if (rv_prev) rv_double <= rv_double + 1;
        end
        rv_prev <= result_valid;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] addr, input logic [11:0] data);
        prog_we    = 1'b1;
        prog_addr  = addr;
        prog_wdata = data;
        tick();
        prog_we = 1'b0;
    endtask

    // Start is driven in cycle 0; returns in cycle 1.
    task automatic launch(input logic [ADDR_W:0] len);
        start    = 1'b1;
        prog_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int from, input int budget, output int cyc);
        cyc = from;
        while (done !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {4'h0, alu_sel, alu_data, alu_enable, result, result_valid, result_index,
                busy, done};
    endfunction

    initial begin
        int en0;
        int rv0;
        int cyc;

        reset      = 1'b1;
        start      = 1'b0;
        prog_len   = '0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_wdata = '0;
        ticks(2);
        reset = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            chk("idle_outs_zero", all_outs(), 32'h0);
            tick();
        end

        // 2: store entry then an add entry
        wr(4'd0, 12'hF05);
        wr(4'd1, 12'h000);
        en0 = en_cnt;
        rv0 = rv_cnt;
        launch(5'd2);
        chk("t2_busy_c1", {31'h0, busy}, 32'h1);
        chk("t2_no_en_c1", {31'h0, alu_enable}, 32'h0);
        tick();
        chk("t2_issue0", {19'h0, alu_enable, alu_sel, alu_data}, {19'h0, 1'b1, 4'hF, 8'h05});
        tick();
        chk("t2_hold0", {19'h0, alu_enable, alu_sel, alu_data}, {19'h0, 1'b0, 4'hF, 8'h05});
        ticks(3);
        chk("t2_store_no_valid", {31'h0, result_valid}, 32'h0);
        tick();
        chk("t2_issue1", {19'h0, alu_enable, alu_sel, alu_data}, {19'h0, 1'b1, 4'h0, 8'h00});
        ticks(4);
        chk("t2_done_c11", {31'h0, done}, 32'h1);
        chk("t2_valid", {31'h0, result_valid}, 32'h1);
        chk("t2_result", {24'h0, result}, 32'h30);
        chk("t2_index", {28'h0, result_index}, 32'h1);
        tick();
        chk("t2_after", {29'h0, done, busy, result_valid}, 32'h0);
        chk("t2_en_count", en_cnt - en0, 32'd2);
        chk("t2_rv_count", rv_cnt - rv0, 32'd1);

        // 3: zero-length program
        en0 = en_cnt;
        launch(5'd0);
        chk("t3_done", {30'h0, done, busy}, 32'h3);
        tick();
        chk("t3_after", {30'h0, done, busy}, 32'h0);
        chk("t3_no_en", en_cnt - en0, 32'd0);

        // 4: start and prog_we while busy are ignored
        wr(4'd0, 12'h211);
        wr(4'd1, 12'h322);
        wr(4'd2, 12'h433);
        en0 = en_cnt;
        rv0 = rv_cnt;
        launch(5'd3);
        ticks(2);
        start      = 1'b1;
        prog_len   = 5'd5;
        prog_we    = 1'b1;
        prog_addr  = 4'd1;
        prog_wdata = 12'h9FF;
        tick();
        start   = 1'b0;
        prog_we = 1'b0;
        wait_done(4, 200, cyc);
        chk("t4_done_cycle", cyc, 32'd16);
        chk("t4_done", {31'h0, done}, 32'h1);
        chk("t4_result", {20'h0, result_index, result}, {20'h0, 4'd2, 8'h67});
        tick();
        chk("t4_en_count", en_cnt - en0, 32'd3);
        chk("t4_rv_count", rv_cnt - rv0, 32'd3);
        launch(5'd3);
        ticks(6);
        chk("t4_mem_intact", {19'h0, alu_enable, alu_sel, alu_data}, {19'h0, 1'b1, 4'h3, 8'h22});
        ticks(4);
        chk("t4_rerun_result", {19'h0, result_valid, result_index, result},
            {19'h0, 1'b1, 4'd1, 8'h55});
        wait_done(11, 200, cyc);
        chk("t4_rerun_done_cycle", cyc, 32'd16);
        tick();

        // 5: reset during WAIT of entry 1
        launch(5'd3);
        ticks(7);
        chk("t5_in_wait", {27'h0, busy, alu_sel}, {27'h0, 1'b1, 4'h3});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_reset_outs", all_outs(), 32'h0);
        en0 = en_cnt;
        ticks(3);
        chk("t5_still_idle", all_outs(), 32'h0);
        chk("t5_no_en", en_cnt - en0, 32'd0);
        launch(5'd1);
        tick();
        chk("t5_replay_issue", {19'h0, alu_enable, alu_sel, alu_data}, {19'h0, 1'b1, 4'h2, 8'h11});
        ticks(4);
        chk("t5_replay_result", {18'h0, done, result_valid, result_index, result},
            {18'h0, 1'b1, 1'b1, 4'd0, 8'h43});
        tick();

        // 6: length beyond depth is clamped
        for (int i = 0; i < 16; i++) wr(4'(i), {4'h2, 8'(i)});
        en0 = en_cnt;
        rv0 = rv_cnt;
        launch(5'd19);
        wait_done(1, 300, cyc);
        chk("t6_done_cycle", cyc, 32'd81);
        chk("t6_done", {31'h0, done}, 32'h1);
        chk("t6_last", {19'h0, result_valid, result_index, result}, {19'h0, 1'b1, 4'd15, 8'h41});
        tick();
        chk("t6_en_count", en_cnt - en0, 32'd16);
        chk("t6_rv_count", rv_cnt - rv0, 32'd16);
        chk("t6_idle", {31'h0, busy}, 32'h0);

        ticks(2);
        chk("valid_never_double", rv_double, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
